keccak_iota_rc_lfsr: RTL
========================

Name: keccak_iota_rc_lfsr

Overview:
Sequential ι-step engine for Keccak-p[b, nr]. It generates round constants on the fly with the FIPS202 Algorithm 5 LFSR instead of a stored table, and supports any lane width w = 2^l (l = 0..6) and a reduced round count. It XORs each constant into lane (0,0) behind valid/ready handshakes, with a registered output. It sits between the χ stage and the round-state register of the permutation datapath.

Parameters:
LANE_W, 64, lane width w; must be a power of two, 1..64; L = log2(LANE_W), elaboration-time derived.
NR, 24, rounds per permutation; legal range 1..12+2L; out-of-range values are an elaboration error.
STEPS_PER_CYCLE, 7, LFSR steps per clock; legal values 1 or 7; anything else is an elaboration error.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  begin a permutation; sampled only in IDLE
busy_o  out  1  high in every state except IDLE
lane_valid_i  in  1  input lane valid
lane_ready_o  out  1  input lane accepted when valid and ready are both high
lane_i  in  LANE_W  lane (0,0) after χ
lane_valid_o  out  1  output lane valid
lane_ready_i  in  1  downstream ready
lane_o  out  LANE_W  lane_i XOR RC[ir]
round_o  out  5  round index ir applied to lane_o
last_o  out  1  lane_o belongs to the final round (ir = 12+2L-1)

Behaviour:
- Reset (asynchronous, rst_n low): state = IDLE, LFSR = SEED, rc_reg = 0, lane_o = 0, lane_valid_o = 0, round_o = 0, last_o = 0, busy_o = 0, lane_ready_o = 0.
- First round index: IR0 = 12+2L-NR. Last round index: IRL = 12+2L-1.
- LFSR: 8-bit register R[0..7], initial value R[0]=1 with all other bits 0.
- One LFSR step: emit R[0], then shift up (R[k+1] <= R[k], R[0] <= 0), then R[0], R[4], R[5], R[6] each ^= old R[7].
- SEED: the initial value advanced 7*IR0 steps, computed at elaboration by a constant function. No runtime skip.
- States:
  - IDLE: start_i=1 loads LFSR = SEED and round counter = IR0, then goes to GEN. start_i in any other state is ignored.
  - GEN: performs 7 LFSR steps in total, STEPS_PER_CYCLE per clock, so GEN lasts 7/STEPS_PER_CYCLE cycles (1 or 7). Emitted bit j (0..6) is rc(7*ir+j). rc_reg[2^j-1] = that bit for j <= L; bits j > L are discarded, but the LFSR still advances 7 steps per round. All other rc_reg bits = 0. Exit to ARMED.
  - ARMED: lane_ready_o = !lane_valid_o || lane_ready_i, and is 0 in every other state. On accept, next edge:
    - lane_o <= lane_i ^ rc_reg, lane_valid_o <= 1, round_o <= ir, last_o <= (ir == IRL).
    - If ir == IRL, go to IDLE; otherwise ir++ and go to GEN.
- Output register: holds lane_o, round_o and last_o stable while lane_valid_o=1 and lane_ready_i=0. lane_valid_o clears on a handshake unless a new lane is accepted on the same edge; simultaneous drain and accept is legal.
- Latency:
  - start_i to lane_ready_o high: 1 + 7/STEPS_PER_CYCLE cycles (2 or 8).
  - Input accept to lane_valid_o: 1 cycle.
  - Accept to next lane_ready_o: 1 + 7/STEPS_PER_CYCLE cycles.
- busy_o drops in the cycle after the final accept. The final lane may still sit in the output register after busy_o drops.
- Reset mid-permutation: everything returns to reset values immediately; the partial permutation is discarded with no output.
- round_o range 0..23; no wrap inside a permutation. LFSR period 255 is never reached (maximum 168 steps).

Test Plan:
- Defaults, start_i, 24 lanes of 0, lane_ready_i=1 -> lane_o sequence 0x0000000000000001, 0x0000000000008082, ..., 0x8000000080008008; last_o only on round 23; lane_ready_o rises 2 cycles after start_i.
- Defaults, lane_i = 0xFFFFFFFFFFFFFFFF at round 0 -> lane_o = 0xFFFFFFFFFFFFFFFE.
- NR=12 -> first lane_o (input 0) = 0x000000008000808B with round_o=12; final lane_o = 0x8000000080008008 with last_o=1.
- LANE_W=8 (18 rounds), inputs 0 -> rounds 0,1,3 yield 0x01, 0x82, 0x00; last_o on round 17.
- STEPS_PER_CYCLE=1 -> lane_ready_o rises 8 cycles after start_i and 8 cycles after each accept; constants are bit-identical to STEPS_PER_CYCLE=7.
- lane_ready_i held 0 for 5 cycles after round-2 output -> lane_o = 0x800000000000808A is held stable and lane_ready_o=0. Then rst_n pulsed low mid-permutation -> all outputs 0, busy_o=0, and a new start_i reproduces round 0 = 0x1.

Source files
------------

// File: rtl/keccak_iota_rc_lfsr.sv
// Keccak-p iota step engine.
// Round constants are produced on the fly by the 8-bit rc(t) LFSR instead of
// being read from a table. The engine XORs RC[ir] into lane (0,0) as lanes
// arrive from the chi stage, and registers the result for the round-state
// register. The LFSR seed is advanced at elaboration to the first round of a
// reduced-round permutation, so no runtime skipping is needed.

module keccak_iota_rc_lfsr #(
    parameter int LANE_W          = 64,
    parameter int NR              = 24,
    parameter int STEPS_PER_CYCLE = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    input  logic              lane_valid_i,
    output logic              lane_ready_o,
    input  logic [LANE_W-1:0] lane_i,
    output logic              lane_valid_o,
    input  logic              lane_ready_i,
    output logic [LANE_W-1:0] lane_o,
    output logic [4:0]        round_o,
    output logic              last_o
);

    localparam int L        = $clog2(LANE_W);
    localparam int NR_MAX   = 12 + 2 * L;
    localparam int IR0      = NR_MAX - NR;
    localparam int IRL      = NR_MAX - 1;
    // Value of step_cnt during the final clock of GEN.
    localparam int GEN_LAST = 7 - STEPS_PER_CYCLE;

    if (LANE_W < 1 || LANE_W > 64 || (LANE_W & (LANE_W - 1)) != 0) begin : g_bad_lane_w
        $error("keccak_iota_rc_lfsr: LANE_W must be a power of two in 1..64");
    end
    if (NR < 1 || NR > NR_MAX) begin : g_bad_nr
        $error("keccak_iota_rc_lfsr: NR must be in 1..12+2L");
    end
    if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 7) begin : g_bad_steps
        $error("keccak_iota_rc_lfsr: STEPS_PER_CYCLE must be 1 or 7");
    end

    // One rc LFSR step: shift up, then fold the bit shifted out of R[7]
    // back into taps R[0], R[4], R[5], R[6]. The emitted bit is R[0]
    // before the step.
    function automatic logic [7:0] lfsr_step(input logic [7:0] r);
        logic [7:0] n;
        n = {r[6:0], 1'b0};
        n = n ^ {1'b0, r[7], r[7], r[7], 3'b000, r[7]};
        return n;
    endfunction

    // LFSR contents at the start of round ir0: the initial value 0x01
    // advanced seven steps per skipped round.
    function automatic logic [7:0] seed_calc(input int ir0);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 7 * ir0; i++) begin
            r = lfsr_step(r);
        end
        return r;
    endfunction

    localparam logic [7:0] SEED = seed_calc(IR0);

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        ARMED
    } state_t;

    state_t      state;
    logic [7:0]  lfsr;
    logic [6:0]  rc_reg;
    logic [2:0]  step_cnt;
    logic [4:0]  ir;

    logic [7:0]  lfsr_nxt;
    logic [6:0]  rc_nxt;
    logic [2:0]  bit_idx;
    logic [63:0] rc_full;
    logic [LANE_W-1:0] rc_lane;
    logic        accept;

    // Advance the LFSR by STEPS_PER_CYCLE steps, capturing each emitted
    // bit into its slot j of the per-round constant bits.
    always_comb begin
        lfsr_nxt = lfsr;
        rc_nxt   = rc_reg;
        bit_idx  = '0;
        for (int k = 0; k < STEPS_PER_CYCLE; k++) begin
            bit_idx         = step_cnt + 3'(k);
            rc_nxt[bit_idx] = lfsr_nxt[0];
            lfsr_nxt        = lfsr_step(lfsr_nxt);
        end
    end

    // Scatter constant bit j to lane position 2^j-1; positions at or above
    // LANE_W fall away when the lane is truncated, discarding bits j > L.
    always_comb begin
        rc_full = '0;
        for (int j = 0; j < 7; j++) begin
            rc_full[(1 << j) - 1] = rc_reg[j];
        end
    end

    assign rc_lane      = rc_full[LANE_W-1:0];
    assign busy_o       = (state != IDLE);
    assign lane_ready_o = (state == ARMED) && (!lane_valid_o || lane_ready_i);
    assign accept       = lane_ready_o && lane_valid_i;

    // Round sequencer plus the output register; the output register can
    // drain and reload on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lfsr         <= SEED;
            rc_reg       <= '0;
            step_cnt     <= '0;
            ir           <= '0;
            lane_o       <= '0;
            lane_valid_o <= 1'b0;
            round_o      <= '0;
            last_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        lfsr     <= SEED;
                        ir       <= 5'(IR0);
                        step_cnt <= '0;
                        state    <= GEN;
                    end
                end
                GEN: begin
                    lfsr   <= lfsr_nxt;
                    rc_reg <= rc_nxt;
                    if (step_cnt == 3'(GEN_LAST)) begin
                        step_cnt <= '0;
                        state    <= ARMED;
                    end else begin
                        step_cnt <= step_cnt + 3'(STEPS_PER_CYCLE);
                    end
                end
                ARMED: begin
                    if (accept) begin
                        if (ir == 5'(IRL)) begin
                            state <= IDLE;
                        end else begin
                            ir    <= ir + 5'd1;
                            state <= GEN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                lane_o       <= lane_i ^ rc_lane;
                lane_valid_o <= 1'b1;
                round_o      <= ir;
                last_o       <= (ir == 5'(IRL));
            end else if (lane_ready_i) begin
                lane_valid_o <= 1'b0;
            end
        end
    end

endmodule
